// File: rtl/exception_ctrl_pkg.sv
// Shared CPU definitions: mode FSM encoding, exception cause codes and the
// PCSrc override codes driven by the exception controller.
package exception_ctrl_pkg;

  // Encoded so that the state bit doubles as the kernel-mode flag.
  typedef enum logic {
    StUser   = 1'b0,
    StKernel = 1'b1
  } state_e;

  localparam logic [1:0] CauseNone  = 2'd0;
  localparam logic [1:0] CauseIrq   = 2'd1;
  localparam logic [1:0] CauseIllop = 2'd2;

  localparam logic [2:0] PcsrcNone  = 3'd0;
  localparam logic [2:0] PcsrcIllop = 3'd4;
  localparam logic [2:0] PcsrcXadr  = 3'd5;

  localparam logic [7:0] IrqCountMax = 8'hFF;

endpackage

// File: rtl/exception_ctrl_irq_edge_latch.sv
// Interrupt request rising-edge detector with a pending latch. A fresh edge
// wins over a clear arriving in the same cycle so no request is lost.
module irq_edge_latch (
  input  logic clk,
  input  logic reset,
  input  logic irq,
  input  logic clr,
  output logic pending
);

  logic irq_q;
  logic pending_q, pending_d;
  logic rise;

  assign rise    = irq & ~irq_q;
  assign pending = pending_q;

  // Set on a rising edge, otherwise hold unless the take clears it.
  always_comb begin
    pending_d = pending_q;
    if (clr) pending_d = 1'b0;
    if (rise) pending_d = 1'b1;
  end

  // Registered irq copy and pending flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_q     <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      irq_q     <= irq;
      pending_q <= pending_d;
    end
  end

endmodule

// File: rtl/exception_ctrl.sv
// Exception controller: decides same-cycle illegal-op / interrupt takes,
// tracks kernel/user mode, last cause, double faults and interrupt count.
module exception_ctrl
  import exception_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC,
  input  logic [31:0] PCplus4,
  input  logic        irq,
  input  logic        illop_dec,
  input  logic        eret,
  output logic        xcpt_valid,
  output logic [2:0]  xcpt_src,
  output logic [31:0] epc_wdata,
  output logic [1:0]  cause,
  output logic        kernel,
  output logic        irq_pending,
  output logic        double_fault,
  output logic [7:0]  irq_count
);

  state_e     state_q, state_d;
  logic [1:0] cause_q, cause_d;
  logic       dfault_q, dfault_d;
  logic [7:0] count_q, count_d;
  logic       take_illop, take_irq;

  irq_edge_latch u_irq_edge_latch (
    .clk     (clk),
    .reset   (reset),
    .irq     (irq),
    .clr     (take_irq),
    .pending (irq_pending)
  );

  // Illegal op outranks a pending interrupt; interrupts are masked in kernel.
  assign take_illop = illop_dec && (state_q == StUser);
  assign take_irq   = irq_pending && !illop_dec && (state_q == StUser);

  // Zero-latency override toward the datapath.
  always_comb begin
    xcpt_valid = 1'b0;
    xcpt_src   = PcsrcNone;
    epc_wdata  = 32'h0;
    if (take_illop) begin
      xcpt_valid = 1'b1;
      xcpt_src   = PcsrcIllop;
      epc_wdata  = PCplus4;
    end else if (take_irq) begin
      // Return to the aborted instruction so it re-executes.
      xcpt_valid = 1'b1;
      xcpt_src   = PcsrcXadr;
      epc_wdata  = PC;
    end
  end

  // Mode FSM and status next-state.
  always_comb begin
    state_d  = state_q;
    cause_d  = cause_q;
    dfault_d = dfault_q;
    count_d  = count_q;
    unique case (state_q)
      StUser: begin
        if (take_illop) begin
          state_d = StKernel;
          cause_d = CauseIllop;
        end else if (take_irq) begin
          state_d = StKernel;
          cause_d = CauseIrq;
          if (count_q != IrqCountMax) count_d = count_q + 8'd1;
        end
      end
      StKernel: begin
        if (illop_dec) dfault_d = 1'b1;
        if (eret) state_d = StUser;
      end
      default: state_d = StKernel;
    endcase
  end

  // State registers; reset lands in kernel to match the reset PC.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StKernel;
      cause_q  <= CauseNone;
      dfault_q <= 1'b0;
      count_q  <= 8'h0;
    end else begin
      state_q  <= state_d;
      cause_q  <= cause_d;
      dfault_q <= dfault_d;
      count_q  <= count_d;
    end
  end

  assign kernel       = (state_q == StKernel);
  assign cause        = cause_q;
  assign double_fault = dfault_q;
  assign irq_count    = count_q;

endmodule
